// File: rtl/acs_unit_pipe.sv
// Registered add-compare-select cell for one trellis state of a rate-1/2 Viterbi decoder.
// Soft-decision branch metrics, saturating path metrics, global normalisation, frame start.
module acs_unit_pipe #(
  parameter int PMW        = 8,
  parameter int SBW        = 3,
  parameter int SW         = 2,
  parameter int INIT_STATE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           valid_in,
  input  logic [SW-1:0]  self_state,
  input  logic [SBW-1:0] sym_i,
  input  logic [SBW-1:0] sym_q,
  input  logic [1:0]     exp_1,
  input  logic [1:0]     exp_2,
  input  logic [PMW-1:0] pm_in_1,
  input  logic [PMW-1:0] pm_in_2,
  input  logic           term_in_1,
  input  logic           term_in_2,
  input  logic [SW-1:0]  addr_in_1,
  input  logic [SW-1:0]  addr_in_2,
  input  logic           norm_in,
  output logic [PMW-1:0] pm_out,
  output logic           term_out,
  output logic [SW-1:0]  addr_out,
  output logic           dec_out,
  output logic           valid_out,
  output logic           pm_msb,
  output logic           sat_flag
);

  localparam logic [PMW-1:0] PM_MAX   = '1;
  localparam logic [SBW-1:0] SB_MAX   = '1;
  localparam logic [SW-1:0]  INIT_IDX = INIT_STATE[SW-1:0];

  function automatic logic [SBW:0] branch_metric(input logic [SBW-1:0] si,
                                                 input logic [SBW-1:0] sq,
                                                 input logic [1:0]     e);
    logic [SBW-1:0] ci;
    logic [SBW-1:0] cq;
    ci = e[1] ? (SB_MAX - si) : si;
    cq = e[0] ? (SB_MAX - sq) : sq;
    return {1'b0, ci} + {1'b0, cq};
  endfunction

  // Removing 2^(PMW-1) from a metric below that value clamps to zero.
  function automatic logic [PMW-1:0] normalise(input logic [PMW-1:0] pm, input logic en);
    if (!en)          return pm;
    if (pm[PMW-1])    return {1'b0, pm[PMW-2:0]};
    return '0;
  endfunction

  function automatic logic [PMW-1:0] saturate(input logic [PMW:0] wide);
    return wide[PMW] ? PM_MAX : wide[PMW-1:0];
  endfunction

  logic [SBW:0]   bm1, bm2;
  logic [PMW:0]   c1_wide, c2_wide;
  logic [PMW-1:0] c1, c2;
  logic           pick2;

  always_comb begin
    bm1     = branch_metric(sym_i, sym_q, exp_1);
    bm2     = branch_metric(sym_i, sym_q, exp_2);
    c1_wide = {1'b0, normalise(pm_in_1, norm_in)} + (PMW+1)'(bm1);
    c2_wide = {1'b0, normalise(pm_in_2, norm_in)} + (PMW+1)'(bm2);
    c1      = saturate(c1_wide);
    c2      = saturate(c2_wide);
    // Equal candidates fall to the smaller branch metric, full ties to branch 2.
    pick2   = (c2 < c1) || ((c2 == c1) && (bm2 <= bm1));
  end

  logic [PMW-1:0] pm_d, pm_q;
  logic           term_d, term_q;
  logic [SW-1:0]  addr_d, addr_q;
  logic           dec_d, dec_q;
  logic           valid_d, valid_q;
  logic           sat_d, sat_q;

  always_comb begin
    pm_d    = pm_q;
    term_d  = term_q;
    addr_d  = addr_q;
    dec_d   = dec_q;
    valid_d = 1'b0;
    sat_d   = sat_q;
    if (start) begin
      pm_d   = (self_state == INIT_IDX) ? '0 : PM_MAX;
      term_d = (self_state != INIT_IDX);
      addr_d = self_state;
      dec_d  = self_state[SW-1];
      sat_d  = 1'b0;
    end else if (valid_in) begin
      valid_d = 1'b1;
      dec_d   = self_state[SW-1];
      term_d  = 1'b0;
      sat_d   = sat_q | (!term_in_1 & c1_wide[PMW]) | (!term_in_2 & c2_wide[PMW]);
      case ({term_in_1, term_in_2})
        2'b00: begin
          pm_d   = pick2 ? c2 : c1;
          addr_d = pick2 ? addr_in_2 : addr_in_1;
        end
        2'b10: begin
          pm_d   = c2;
          addr_d = addr_in_2;
        end
        2'b01: begin
          pm_d   = c1;
          addr_d = addr_in_1;
        end
        default: begin
          pm_d   = PM_MAX;
          term_d = 1'b1;
          addr_d = addr_in_1;
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm_q    <= '0;
      term_q  <= 1'b0;
      addr_q  <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      pm_q    <= pm_d;
      term_q  <= term_d;
      addr_q  <= addr_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign pm_out    = pm_q;
  assign term_out  = term_q;
  assign addr_out  = addr_q;
  assign dec_out   = dec_q;
  assign valid_out = valid_q;
  assign pm_msb    = pm_q[PMW-1];
  assign sat_flag  = sat_q;

endmodule
